// File: rtl/sha_stream.sv
// Byte-stream front end for sha: loads an Nl-byte message, pulses Enable, and returns the digest on a valid/ready port.
// Optional watchdog on the WAIT state is built when SHA_STREAM_TIMEOUT_EN is defined.
module sha_stream #(
  parameter int Nl = 64,
  parameter int Nk = 256,
  parameter int Nt = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    In_Data,
  input  logic          In_Valid,
  output logic          In_Ready,
  output logic [7:0]    Sha_Data [0:Nl-1],
  output logic          Sha_Enable,
  input  logic [Nk-1:0] Sha_Hash,
  input  logic          Sha_Ready,
  output logic [Nk-1:0] Out_Hash,
  output logic          Out_Valid,
  input  logic          Out_Ready,
  output logic          Busy,
  output logic          Error
);

  localparam int CW = $clog2(Nl + 1);
  localparam int IW = (Nl > 1) ? $clog2(Nl) : 1;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    buf_q [0:Nl-1];
  logic [7:0]    buf_d [0:Nl-1];
  logic [Nk-1:0] hash_q, hash_d;
  logic [IW-1:0] idx_s;
  logic          timeout_s;

  assign idx_s = cnt_q[IW-1:0];

`ifdef SHA_STREAM_TIMEOUT_EN
  localparam int TW = $clog2(Nt + 1);
  logic [TW-1:0] wd_q, wd_d;
  logic          err_q, err_d;

  // Watchdog counts WAIT cycles without Sha_Ready; the error flag is sticky until reset.
  always_comb begin
    timeout_s = (state_q == S_WAIT) && !Sha_Ready && (wd_q == TW'(Nt - 1));
    err_d     = err_q | timeout_s;
    if ((state_q == S_WAIT) && !Sha_Ready && !timeout_s) begin
      wd_d = wd_q + {{(TW-1){1'b0}}, 1'b1};
    end else begin
      wd_d = '0;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign Error = err_q;
`else
  assign timeout_s = 1'b0;
  assign Error     = (Nt < 0) ? 1'b1 : 1'b0;
`endif

  // Next-state, byte capture and digest capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    hash_d  = hash_q;
    case (state_q)
      S_LOAD: begin
        if (In_Valid) begin
          buf_d[idx_s] = In_Data;
          if (cnt_q == CW'(Nl - 1)) begin
            cnt_d   = '0;
            state_d = S_START;
          end else begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (Sha_Ready) begin
          hash_d  = Sha_Hash;
          state_d = S_OUT;
        end else if (timeout_s) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_OUT: begin
        if (Out_Ready) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_OUT;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // State, counter, message buffer and digest registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      hash_q  <= '0;
      for (int i = 0; i < Nl; i++) begin
        buf_q[i] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hash_q  <= hash_d;
      for (int i = 0; i < Nl; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  // All handshake outputs decode the state register directly.
  assign In_Ready   = (state_q == S_LOAD);
  assign Sha_Enable = (state_q == S_START);
  assign Out_Valid  = (state_q == S_OUT);
  assign Busy       = (state_q != S_LOAD);
  assign Out_Hash   = hash_q;
  assign Sha_Data   = buf_q;

endmodule

// File: tb/tb_sha_stream.sv
// Directed bench for sha_stream with a behavioural sha stand-in and a digest scoreboard.
module tb_sha_stream;

  localparam int NL = 3;
  localparam int NK = 256;
  localparam int NT = 16;
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    sha_data [0:NL-1];
  logic          sha_enable;
  logic [NK-1:0] sha_hash;
  logic          sha_ready;
  logic [NK-1:0] out_hash;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          error;

  int checks = 0;
  int failures = 0;
  int en_pulses = 0;
  int lat = 0;
  logic stub_hold = 1'b0;
  logic [255:0] exp_q [$];

  sha_stream #(.Nl(NL), .Nk(NK), .Nt(NT)) dut (
    .clk(clk), .rst(rst),
    .In_Data(in_data), .In_Valid(in_valid), .In_Ready(in_ready),
    .Sha_Data(sha_data), .Sha_Enable(sha_enable),
    .Sha_Hash(sha_hash), .Sha_Ready(sha_ready),
    .Out_Hash(out_hash), .Out_Valid(out_valid), .Out_Ready(out_ready),
    .Busy(busy), .Error(error)
  );

  always #5 clk = ~clk;

  // Digest the sha stand-in returns for a 3-byte message.
  function automatic logic [255:0] model_digest(input logic [23:0] m);
    if (m == 24'h616263) return ABC_DIGEST;
    return {8{m ^ 24'hA5A5A5, 8'h3C}};
  endfunction

  // sha stand-in: reads the buffer a few cycles after Enable and pulses Ready.
  always @(posedge clk) begin
    #2;
    if (sha_ready) sha_ready = 1'b0;
    if (sha_enable) begin
      en_pulses++;
      if (!stub_hold) lat = 4;
    end else if (lat > 0) begin
      lat--;
      if (lat == 0) begin
        sha_hash  = model_digest({sha_data[0], sha_data[1], sha_data[2]});
        sha_ready = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_buf(input string tag, input logic [23:0] m);
    chk(tag, {232'd0, sha_data[0], sha_data[1], sha_data[2]}, {232'd0, m});
  endtask

  // Streams the first nb bytes of m, with gap idle cycles between bytes.
  task automatic send_msg(input logic [23:0] m, input int gap, input int nb);
    int n;
    for (int i = 0; i < nb; i++) begin
      in_data  = m[23-8*i -: 8];
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("in_ready_wait", {255'd0, (n < 100)}, 256'd1);
      @(negedge clk);
      if (gap > 0 && i < nb - 1) begin
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        chk("idle_in_ready", {255'd0, in_ready}, 256'd1);
      end
    end
    in_valid = 1'b0;
  endtask

  // Waits for the digest, compares against the scoreboard, optionally stalls, then handshakes.
  task automatic recv(input string tag, input logic [23:0] m, input int hold);
    logic [255:0] exp;
    logic [255:0] held;
    logic prev_rdy;
    int n;
    exp = 256'd0;
    chk({tag, "_sb_nonempty"}, {255'd0, (exp_q.size() > 0)}, 256'd1);
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    n = 0;
    prev_rdy = 1'b0;
    while (!out_valid && n < 200) begin
      prev_rdy = sha_ready;
      @(negedge clk);
      n++;
    end
    chk({tag, "_out_timeout"}, {255'd0, (n < 200)}, 256'd1);
    chk({tag, "_valid_after_ready"}, {255'd0, prev_rdy}, 256'd1);
    chk({tag, "_hash"}, out_hash, exp);
    chk_buf({tag, "_buf_held"}, m);
    held = out_hash;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hEE;
      @(negedge clk);
      chk({tag, "_bp_valid"}, {255'd0, out_valid}, 256'd1);
      chk({tag, "_bp_hash"}, out_hash, held);
      chk({tag, "_bp_in_ready"}, {255'd0, in_ready}, 256'd0);
      chk_buf({tag, "_bp_buf"}, m);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, {255'd0, out_valid}, 256'd0);
    chk({tag, "_in_ready_back"}, {255'd0, in_ready}, 256'd1);
  endtask

  task automatic run_msg(input string tag, input logic [23:0] m, input int gap, input int hold);
    en_pulses = 0;
    exp_q.push_back(model_digest(m));
    send_msg(m, gap, 3);
    chk({tag, "_enable"}, {255'd0, sha_enable}, 256'd1);
    chk({tag, "_busy"}, {255'd0, busy}, 256'd1);
    chk({tag, "_in_ready_low"}, {255'd0, in_ready}, 256'd0);
    chk_buf({tag, "_buf"}, m);
    recv(tag, m, hold);
    chk({tag, "_enable_pulses"}, en_pulses, 256'd1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, {255'd0, in_ready}, 256'd1);
    chk({tag, "_enable"}, {255'd0, sha_enable}, 256'd0);
    chk({tag, "_out_valid"}, {255'd0, out_valid}, 256'd0);
    chk({tag, "_busy"}, {255'd0, busy}, 256'd0);
    chk({tag, "_error"}, {255'd0, error}, 256'd0);
    chk({tag, "_out_hash"}, out_hash, 256'd0);
    chk_buf({tag, "_buf"}, 24'h000000);
  endtask

  initial begin
    rst = 1'b0;
    in_data = 8'h00;
    in_valid = 1'b0;
    out_ready = 1'b0;
    sha_ready = 1'b0;
    sha_hash = '0;
    #12;
    chk_reset_state("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_msg("basic", 24'h616263, 0, 0);
    run_msg("bubble", 24'h616263, 2, 0);
    run_msg("backpressure", 24'h616263, 10, 10);
    run_msg("b2b_first", 24'h616263, 0, 0);
    run_msg("b2b_second", 24'h616264, 0, 0);

    send_msg(24'h616263, 0, 2);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_state("midload_reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_msg("after_reset", 24'h616263, 0, 0);

    stub_hold = 1'b1;
    send_msg(24'h616263, 0, 3);
    chk("wd_enable", {255'd0, sha_enable}, 256'd1);
    for (int i = 0; i < NT; i++) begin
      @(negedge clk);
      chk("wd_busy", {255'd0, busy}, 256'd1);
      chk("wd_error_low", {255'd0, error}, 256'd0);
      chk("wd_no_valid", {255'd0, out_valid}, 256'd0);
    end
    @(negedge clk);
`ifdef SHA_STREAM_TIMEOUT_EN
    chk("wd_error_set", {255'd0, error}, 256'd1);
    chk("wd_back_to_load", {255'd0, busy}, 256'd0);
    chk("wd_no_valid_end", {255'd0, out_valid}, 256'd0);
    chk("wd_hash_kept", out_hash, ABC_DIGEST);
`else
    repeat (20) @(negedge clk);
    chk("wd_off_error", {255'd0, error}, 256'd0);
    chk("wd_off_waiting", {255'd0, busy}, 256'd1);
    chk("wd_off_no_valid", {255'd0, out_valid}, 256'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha_stream.md
# sha_stream

Byte-stream front end for the `sha` top. It collects an Nl-byte message from a valid/ready byte stream into a local buffer, holds the buffer stable on the `sha` data input, and pulses `sha` Enable once. It then waits for `sha` Ready, registers the Nk-bit digest, and presents it on a valid/ready output handshake. It sits directly upstream of `sha` and is the only driver of its Data and Enable inputs.

## Interface
Parameters:
- Nl, 64: message length in bytes; must match `sha_const` Nl; Nl ≥ 1.
- Nk, 256: digest width in bits; must match `sha_const` Nk.
- Nt, 4096: watchdog limit in cycles; used only with `SHA_STREAM_TIMEOUT_EN`.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- In_Data  in  8  message byte.
- In_Valid  in  1  In_Data valid.
- In_Ready  out  1  byte accepted at an edge where In_Valid & In_Ready.
- Sha_Data  out  8 × [0:Nl-1]  message buffer to `sha` Data; byte 0 = first accepted.
- Sha_Enable  out  1  one-cycle start pulse to `sha` Enable.
- Sha_Hash  in  Nk  digest from `sha` Hash.
- Sha_Ready  in  1  `sha` Ready; marks Sha_Hash as valid.
- Out_Hash  out  Nk  registered digest.
- Out_Valid  out  1  Out_Hash valid.
- Out_Ready  in  1  consumer accepts at an edge where Out_Valid & Out_Ready.
- Busy  out  1  high in any state other than LOAD.
- Error  out  1  sticky watchdog flag; constant 0 without the macro.

## Operation
- The FSM has four states: LOAD, START, WAIT, OUT. The reset state is LOAD.
- LOAD:
  - In_Ready = 1.
  - Each accepted byte is written to buffer[cnt], then cnt increments.
  - The counter is $clog2(Nl+1) bits wide.
  - Accepting the byte at cnt = Nl-1 moves to START and clears cnt to 0.
- START:
  - Sha_Enable = 1 for exactly this one cycle.
  - Moves unconditionally to WAIT.
- WAIT:
  - Sha_Ready = 1 captures Sha_Hash into Out_Hash and moves to OUT.
- OUT:
  - Out_Valid = 1; Out_Hash is held stable.
  - Handshake moves to LOAD.
- The buffer is stable from the last accepted byte until return to LOAD. `sha` re-reads Data across blocks, so the buffer must not change in START, WAIT or OUT.
- In_Valid outside LOAD is ignored; In_Ready = 0, so no byte is lost.
- Sha_Ready outside WAIT is ignored.
- Sha_Ready in the same cycle as the START pulse is ignored, because that cycle is START, not WAIT.
- Error clears only on reset. Entering LOAD does not clear it.

## Timing
- Reset values:
  - In_Ready = 1 (state LOAD).
  - Sha_Enable = 0, Out_Valid = 0, Busy = 0, Error = 0.
  - Out_Hash = 0, all buffer bytes = 0, cnt = 0.
- Throughput: one byte per cycle while In_Valid stays high. Nl bytes need Nl cycles.
- The last byte accepted at edge k gives:
  - Sha_Enable high in cycle k+1.
  - Busy high from cycle k+1.
- Sha_Ready high in cycle m (in WAIT) gives Out_Valid high and Out_Hash valid from cycle m+1.
- Out handshake at edge n gives In_Ready high in cycle n+1. There is no overlap between the output and the next message load.
- Sha_Enable and Out_Valid are registered outputs (state decode only). In_Ready is state decode.
- Reset asserted in any state:
  - Immediately returns to LOAD.
  - Drops Sha_Enable and Out_Valid.
  - Clears cnt, the buffer and Out_Hash.
  - A partially loaded message is discarded.

## Configuration
- Macro `SHA_STREAM_TIMEOUT_EN`.
- Defined:
  - A watchdog counter runs in WAIT, starting at 0 on entry.
  - If Sha_Ready is not seen after Nt cycles in WAIT, Error is set to 1.
  - The FSM then returns to LOAD without asserting Out_Valid; Out_Hash is unchanged.
  - The watchdog counter is cleared whenever the FSM is outside WAIT.
- Undefined:
  - No watchdog logic is built; WAIT waits indefinitely.
  - Error is tied to 0.

## Test plan
- **Basic digest.** Nl=3, Nk=256, stream 0x61, 0x62, 0x63 with In_Valid held high.
  - Exactly one Sha_Enable pulse, in the cycle after the third byte.
  - Out_Hash = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
  - Out_Valid rises one cycle after Sha_Ready.
- **Input bubbles.** Same bytes with In_Valid low for 2 cycles between each byte.
  - Buffer = {0x61, 0x62, 0x63}.
  - Same digest as the basic test.
- **Output backpressure.** Hold Out_Ready = 0 for 10 cycles after Out_Valid, and drive In_Valid throughout.
  - Out_Valid and Out_Hash stay stable; In_Ready = 0; no byte is accepted.
  - The handshake then gives In_Ready = 1 in the next cycle.
- **Back-to-back messages.** Two messages: "abc", then 0x61, 0x62, 0x64.
  - Two distinct correct digests, delivered in order.
  - The buffer is not modified during the first hash.
- **Reset mid-load.** Assert rst after 2 of 3 bytes.
  - All outputs go to their reset values asynchronously.
  - A fresh "abc" afterwards yields the correct digest.
- **Watchdog.** Build with `SHA_STREAM_TIMEOUT_EN`, Nt=16, and hold Sha_Ready at 0.
  - Error = 1 after 16 WAIT cycles; FSM returns to LOAD; Out_Valid never asserts.
  - Without the macro, the same stimulus leaves the FSM in WAIT with Error = 0.
